hwregs: RTL
===========

Name: hwregs

Overview:
- Memory-mapped peripheral register block directly downstream of the address decoder; serves the CPU window E000_0000–E000_FFFF, of which the decoder passes the low 16 address bits.
- Holds the LED and seven-segment output registers, the synchronised switch inputs, a microsecond timer, and UART TX/RX byte FIFOs.
- Returns tagged read responses one cycle after each read request.
- The decoder forwards the CPU request tag on hwregs_tag alongside each request.

Parameters:
- FIFO_DEPTH, 16, entries in each UART FIFO (power of two, at least 2)
- TIMER_DIV, 100, clock cycles per timer tick (100 MHz clock gives 1 µs per tick)

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- hwregs_request  in  1  request valid this cycle
- hwregs_write  in  1  1 = write, 0 = read
- hwregs_address  in  16  byte address; bits [1:0] ignored
- hwregs_wmask  in  4  byte enables for a write
- hwregs_wdata  in  32  write data
- hwregs_tag  in  9  request tag, echoed on the response
- hwregs_rvalid  out  1  read response valid
- hwregs_rtag  out  9  tag of the request being answered
- hwregs_rdata  out  32  read data
- seven_seg  out  24  seven-segment display register
- ledr  out  10  LED register
- sw  in  10  asynchronous switch inputs
- uart_tx_valid  out  1  TX FIFO not empty
- uart_tx_ready  in  1  UART transmitter accepts a byte
- uart_tx_data  out  8  byte at the TX FIFO head
- uart_rx_valid  in  1  received byte strobe, one cycle
- uart_rx_data  in  8  received byte

Behaviour:
Reset (asynchronous)
- All outputs go to 0, FIFOs empty, timer and prescaler 0, overflow flag clear.
- A read in flight when reset asserts is lost and produces no response.

Register map (word offsets)
- 0x00 SEVEN_SEG: read/write, bits [23:0]; byte-masked writes.
- 0x04 LEDR: read/write, bits [9:0]; byte-masked writes.
- 0x08 SW: read-only. sw passes through a 2-flop synchroniser; reads return the synchronised value, zero-extended.
- 0x0C TIMER: read returns the 32-bit tick count. Any write sets the count and prescaler to 0. The count wraps FFFF_FFFF → 0.
- 0x10 UART_TX: a write with wmask[0]=1 pushes wdata[7:0]. A push to a full FIFO is dropped. Reads return the free-slot count.
- 0x14 UART_RX: a read pops and returns the head byte, zero-extended. If the FIFO is empty, the read returns FFFF_FFFF and does not pop. Writes are ignored.
- 0x18 UART_STAT: bit0 = RX overflow (sticky), bit1 = TX full, bit2 = RX empty. Writing 1 to bit0 clears it.
- Unmapped offsets: reads return 0 with normal rvalid; writes are ignored.
- Writes to read-only registers are ignored.

Timing
- A read request in cycle N gives hwregs_rvalid=1 with rdata and rtag (= hwregs_tag) in cycle N+1, for exactly one cycle.
- rvalid is 0 in every other cycle, and rdata/rtag are driven to 0 then.
- Back-to-back reads are supported at one per cycle. No stall; the block always accepts requests.
- Writes take effect at the clock edge ending the request cycle and produce no response.

TX FIFO
- The head is presented on uart_tx_data while uart_tx_valid is high.
- A pop occurs when valid && ready.
- Push and pop in the same cycle are both honoured, including when the FIFO is full.

RX FIFO
- Pushed on uart_rx_valid.
- A push while full is dropped and sets the overflow flag, unless a CPU pop happens in the same cycle, in which case both are honoured.
- A simultaneous overflow-set and write-1-clear leaves the flag set.

Timer
- The prescaler counts 0..TIMER_DIV-1; the tick count increments when the prescaler wraps.

Decomposition:
- Package hwregs_pkg holds the address offset localparams (ADDR_SEVEN_SEG … ADDR_UART_STAT), the UART_STAT bit positions, and the RX empty read value FFFF_FFFF.
- One sub-module, byte_fifo: parameterised depth, 8-bit data, push/pop/full/empty/count, with simultaneous push/pop handled at full and empty. It is instantiated twice, for TX and RX.

Test Plan:
- Reset, then write 0x00123456 to 0x00 with wmask=0011; read with tag 0x1A5 → next cycle rvalid=1, rdata=0x00003456, rtag=0x1A5; seven_seg=0x003456.
- Hold uart_tx_ready=0 and write 17 bytes (0x41..0x51) to 0x10 → read 0x10 returns 0 and STAT bit1=1. Then raise uart_tx_ready → bytes 0x41..0x50 emitted in order; 0x51 dropped.
- Read 0x14 while the RX FIFO is empty → FFFF_FFFF. Push 0x7E, then read → 0x7E; the next read → FFFF_FFFF.
- Push 17 RX bytes with no reads → STAT bit0=1. Write 1 to STAT → bit0=0; the FIFO holds the first 16 bytes.
- TIMER_DIV=4: write to 0x0C, wait 40 cycles, read → 10 (±1). Preload near FFFF_FFFF and confirm it wraps to 0.
- Issue reads on 3 consecutive cycles with tags 1,2,3 → rvalid for 3 consecutive cycles, tags 1,2,3 in order. Assert reset mid-stream → rvalid=0 immediately, and all outputs are 0.

Source files
------------

// File: rtl/hwregs_pkg.sv
// Shared constants for the hwregs peripheral block: register word offsets,
// UART status bit positions and the value returned by a read of an empty RX FIFO.
package hwregs_pkg;

  localparam logic [15:0] ADDR_SEVEN_SEG = 16'h0000;
  localparam logic [15:0] ADDR_LEDR      = 16'h0004;
  localparam logic [15:0] ADDR_SW        = 16'h0008;
  localparam logic [15:0] ADDR_TIMER     = 16'h000C;
  localparam logic [15:0] ADDR_UART_TX   = 16'h0010;
  localparam logic [15:0] ADDR_UART_RX   = 16'h0014;
  localparam logic [15:0] ADDR_UART_STAT = 16'h0018;

  localparam int STAT_OVF_BIT     = 0;
  localparam int STAT_TXFULL_BIT  = 1;
  localparam int STAT_RXEMPTY_BIT = 2;

  localparam logic [31:0] RX_EMPTY_VALUE = 32'hFFFF_FFFF;

endpackage

// File: rtl/hwregs_byte_fifo.sv
// Byte-wide circular FIFO with occupancy count. A push while full is still
// accepted when a pop happens in the same cycle; a pop while empty is ignored.
module byte_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       push_i,
  input  logic [7:0]                 data_i,
  input  logic                       pop_i,
  output logic [7:0]                 data_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [7:0]    memQ [DEPTH];
  logic [AW-1:0] rdPtrQ, wrPtrQ;
  logic [CW-1:0] countQ, countD;
  logic          doPush, doPop;

  assign empty_o = (countQ == '0);
  assign full_o  = (countQ == CW'(DEPTH));
  assign count_o = countQ;
  assign doPop   = pop_i && !empty_o;
  assign doPush  = push_i && (!full_o || doPop);
  assign data_o  = empty_o ? 8'h00 : memQ[rdPtrQ];

  always_comb begin
    countD = countQ;
    case ({doPush, doPop})
      2'b10:   countD = countQ + CW'(1);
      2'b01:   countD = countQ - CW'(1);
      default: countD = countQ;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rdPtrQ <= '0;
      wrPtrQ <= '0;
      countQ <= '0;
    end else begin
      if (doPush) wrPtrQ <= wrPtrQ + AW'(1);
      if (doPop)  rdPtrQ <= rdPtrQ + AW'(1);
      countQ <= countD;
    end
  end

  // Storage needs no reset: the empty flag masks stale contents.
  always_ff @(posedge clock) begin
    if (doPush) memQ[wrPtrQ] <= data_i;
  end

endmodule

// File: rtl/hwregs.sv
// Peripheral register block behind the address decoder: LEDs, seven-segment,
// synchronised switches, tick timer and UART byte FIFOs, with tagged read responses.
module hwregs
  import hwregs_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int TIMER_DIV  = 100
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        hwregs_request,
  input  logic        hwregs_write,
  input  logic [15:0] hwregs_address,
  input  logic [3:0]  hwregs_wmask,
  input  logic [31:0] hwregs_wdata,
  input  logic [8:0]  hwregs_tag,
  output logic        hwregs_rvalid,
  output logic [8:0]  hwregs_rtag,
  output logic [31:0] hwregs_rdata,
  output logic [23:0] seven_seg,
  output logic [9:0]  ledr,
  input  logic [9:0]  sw,
  output logic        uart_tx_valid,
  input  logic        uart_tx_ready,
  output logic [7:0]  uart_tx_data,
  input  logic        uart_rx_valid,
  input  logic [7:0]  uart_rx_data
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [23:0] segQ, segD;
  logic [9:0]  ledQ, ledD;
  logic [9:0]  swMetaQ, swSyncQ;
  logic [31:0] timerQ, timerD, prescQ, prescD;
  logic        ovfQ, ovfD;
  logic        rvalidQ;
  logic [8:0]  rtagQ;
  logic [31:0] rdataQ, rdataD;

  logic [15:0]   wordAddr;
  logic          wrEn, rdEn, txPush, rxPop, rxDrop, ovfClear;
  logic          txFull, txEmpty, rxFull, rxEmpty;
  logic [7:0]    rxHead;
  logic [CW-1:0] txCount, rxCount;
  logic [31:0]   statWord;
  logic          unusedBits;

  assign wordAddr = {hwregs_address[15:2], 2'b00};
  assign wrEn     = hwregs_request && hwregs_write;
  assign rdEn     = hwregs_request && !hwregs_write;
  assign txPush   = wrEn && (wordAddr == ADDR_UART_TX) && hwregs_wmask[0];
  assign rxPop    = rdEn && (wordAddr == ADDR_UART_RX) && !rxEmpty;
  assign rxDrop   = uart_rx_valid && rxFull && !rxPop;
  assign ovfClear = wrEn && (wordAddr == ADDR_UART_STAT) && hwregs_wmask[0]
                    && hwregs_wdata[STAT_OVF_BIT];
  assign unusedBits = ^{hwregs_wdata[31:24], hwregs_address[1:0], hwregs_wmask[3], rxCount};

  byte_fifo #(.DEPTH(FIFO_DEPTH)) txFifo (
    .clock   (clock),
    .reset   (reset),
    .push_i  (txPush),
    .data_i  (hwregs_wdata[7:0]),
    .pop_i   (uart_tx_ready),
    .data_o  (uart_tx_data),
    .full_o  (txFull),
    .empty_o (txEmpty),
    .count_o (txCount)
  );

  byte_fifo #(.DEPTH(FIFO_DEPTH)) rxFifo (
    .clock   (clock),
    .reset   (reset),
    .push_i  (uart_rx_valid),
    .data_i  (uart_rx_data),
    .pop_i   (rxPop),
    .data_o  (rxHead),
    .full_o  (rxFull),
    .empty_o (rxEmpty),
    .count_o (rxCount)
  );

  // Register writes, timer prescaling and the sticky overflow flag (set wins over clear).
  always_comb begin
    segD   = segQ;
    ledD   = ledQ;
    timerD = timerQ;
    prescD = prescQ;
    ovfD   = ovfQ;
    if (wrEn && wordAddr == ADDR_SEVEN_SEG) begin
      if (hwregs_wmask[0]) segD[7:0]   = hwregs_wdata[7:0];
      if (hwregs_wmask[1]) segD[15:8]  = hwregs_wdata[15:8];
      if (hwregs_wmask[2]) segD[23:16] = hwregs_wdata[23:16];
    end
    if (wrEn && wordAddr == ADDR_LEDR) begin
      if (hwregs_wmask[0]) ledD[7:0] = hwregs_wdata[7:0];
      if (hwregs_wmask[1]) ledD[9:8] = hwregs_wdata[9:8];
    end
    if (wrEn && wordAddr == ADDR_TIMER) begin
      timerD = '0;
      prescD = '0;
    end else if (prescQ == 32'(TIMER_DIV - 1)) begin
      prescD = '0;
      timerD = timerQ + 32'd1;
    end else begin
      prescD = prescQ + 32'd1;
    end
    if (rxDrop)        ovfD = 1'b1;
    else if (ovfClear) ovfD = 1'b0;
  end

  always_comb begin
    statWord                   = '0;
    statWord[STAT_OVF_BIT]     = ovfQ;
    statWord[STAT_TXFULL_BIT]  = txFull;
    statWord[STAT_RXEMPTY_BIT] = rxEmpty;
    rdataD = '0;
    case (wordAddr)
      ADDR_SEVEN_SEG: rdataD = {8'h00, segQ};
      ADDR_LEDR:      rdataD = {22'h0, ledQ};
      ADDR_SW:        rdataD = {22'h0, swSyncQ};
      ADDR_TIMER:     rdataD = timerQ;
      ADDR_UART_TX:   rdataD = 32'(FIFO_DEPTH) - {{(32-CW){1'b0}}, txCount};
      ADDR_UART_RX:   rdataD = rxEmpty ? RX_EMPTY_VALUE : {24'h0, rxHead};
      ADDR_UART_STAT: rdataD = statWord;
      default:        rdataD = '0;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      segQ    <= '0;
      ledQ    <= '0;
      swMetaQ <= '0;
      swSyncQ <= '0;
      timerQ  <= '0;
      prescQ  <= '0;
      ovfQ    <= 1'b0;
      rvalidQ <= 1'b0;
      rtagQ   <= '0;
      rdataQ  <= '0;
    end else begin
      segQ    <= segD;
      ledQ    <= ledD;
      swMetaQ <= sw;
      swSyncQ <= swMetaQ;
      timerQ  <= timerD;
      prescQ  <= prescD;
      ovfQ    <= ovfD;
      rvalidQ <= rdEn;
      rtagQ   <= rdEn ? hwregs_tag : 9'h000;
      rdataQ  <= rdEn ? rdataD : 32'h0;
    end
  end

  assign hwregs_rvalid = rvalidQ;
  assign hwregs_rtag   = rtagQ;
  assign hwregs_rdata  = rdataQ;
  assign seven_seg     = segQ;
  assign ledr          = ledQ;
  assign uart_tx_valid = !txEmpty;

endmodule
